irq_arbiter: RTL and testbench

//  Upstream companion of the interrupt controller: collects N_SRC peripheral interrupt lines,

---
 rtl/irq_arbiter.sv | 137 +++++++++++++
 tb/tb_irq_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: synchronises peripheral interrupt lines, latches rising edges, and
// presents the lowest-index enabled pending source to the interrupt controller.
`timescale 1ns/1ps
module irq_arbiter #(
  parameter int unsigned N_SRC      = 16,
  parameter logic [15:0] EDGE_MASK  = 16'h0000,
  parameter logic [31:0] CAUSE_BASE = 32'h1000_0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] irq_en_i,
  input  logic             irq_taken_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_cause_o,
  output logic [3:0]       irq_id_o,
  output logic [N_SRC-1:0] irq_clr_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  localparam logic [N_SRC-1:0] EDGE_SRC = EDGE_MASK[N_SRC-1:0];
  localparam logic [N_SRC-1:0] LSB_ONE  = N_SRC'(1'b1);

  logic [N_SRC-1:0] s1_q, s2_q, s3_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] pending_s, eligible_s, id_onehot_s;
  logic             id_eligible_s;
  logic [3:0]       sel_s;
  logic [1:0]       state_q, state_d;
  logic [3:0]       id_q, id_d;
  logic             req_q, req_d;
  logic [31:0]      cause_q, cause_d;
  logic [3:0]       id_out_q, id_out_d;
  logic [N_SRC-1:0] clr_q, clr_d;

  // Two-stage synchroniser plus one history stage for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_q <= {N_SRC{1'b0}};
      s2_q <= {N_SRC{1'b0}};
      s3_q <= {N_SRC{1'b0}};
    end else begin
      s1_q <= irq_src_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Level sources follow the synchronised line; edge sources use the latched bit.
  assign pending_s     = (pend_q & EDGE_SRC) | (s2_q & ~EDGE_SRC);
  assign eligible_s    = pending_s & irq_en_i;
  assign id_onehot_s   = LSB_ONE << id_q;
  assign id_eligible_s = |(eligible_s & id_onehot_s);

  // Lowest-index eligible source wins.
  always_comb begin
    sel_s = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      sel_s = eligible_s[i] ? 4'(i) : sel_s;
    end
  end

  // Next-state, pending update and next output values.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr_d   = {N_SRC{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_d = ST_REQ;
          id_d    = sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A taken pulse beats a simultaneous withdraw.
        if (irq_taken_i) begin
          state_d = ST_SVC;
        end else if (!id_eligible_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SVC: begin
        if (irq_ret_i) begin
          state_d = ST_IDLE;
          clr_d   = id_onehot_s;
        end else begin
          state_d = ST_SVC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // New edges are OR-ed in after the clear so a coincident edge survives.
    pend_d   = ((pend_q & ~clr_d) | (s2_q & ~s3_q)) & EDGE_SRC;
    req_d    = (state_d == ST_REQ);
    cause_d  = (state_d == ST_IDLE) ? 32'd0 : (CAUSE_BASE + {28'd0, id_d});
    id_out_d = (state_d == ST_IDLE) ? 4'd0 : id_d;
  end

  // State, selection, pending and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      id_q     <= 4'd0;
      pend_q   <= {N_SRC{1'b0}};
      req_q    <= 1'b0;
      cause_q  <= 32'd0;
      id_out_q <= 4'd0;
      clr_q    <= {N_SRC{1'b0}};
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      cause_q  <= cause_d;
      id_out_q <= id_out_d;
      clr_q    <= clr_d;
    end
  end

  assign irq_req_o   = req_q;
  assign irq_cause_o = cause_q;
  assign irq_id_o    = id_out_q;
  assign irq_clr_o   = clr_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed vector table, hand-written
// corner-case sequences, and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_irq_arbiter;

  localparam logic [15:0] EDGE = 16'hEF7F;  // sources 7 and 12 are level-triggered
  localparam logic [31:0] CB   = 32'h1000_0010;
  localparam logic [15:0] ONES = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] src = 16'h0;
  logic [15:0] en = 16'h0;
  logic        taken = 1'b0;
  logic        ret = 1'b0;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;
  logic [3:0]  irq_id_o;
  logic [15:0] irq_clr_o;

  always #5 clk = ~clk;

  irq_arbiter #(.N_SRC(16), .EDGE_MASK(EDGE), .CAUSE_BASE(CB)) dut (
    .clk_i(clk), .rst_i(rst_n), .irq_src_i(src), .irq_en_i(en),
    .irq_taken_i(taken), .irq_ret_i(ret),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
    .irq_id_o(irq_id_o), .irq_clr_o(irq_clr_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit model_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: sample history queue, latched edge bits, phase of the handshake.
  logic [15:0] samp[$];
  logic [15:0] m_pend;
  int          m_mode;   // 0 idle, 1 requesting, 2 in service
  int          m_id;
  logic        m_req;
  logic [31:0] m_cause;
  logic [3:0]  m_idout;
  logic [15:0] m_clr;

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    samp = '{16'h0, 16'h0, 16'h0};
    m_pend = 16'h0; m_mode = 0; m_id = 0;
    m_req = 1'b0; m_cause = 32'h0; m_idout = 4'h0; m_clr = 16'h0;
  endtask

  task automatic model_edge();
    logic [15:0] s2, s3, rise, pend, elig;
    s2 = samp[1];
    s3 = samp[2];
    rise = s2 & ~s3 & EDGE;
    pend = m_pend | (s2 & ~EDGE);
    elig = pend & en;
    m_clr = 16'h0;
    case (m_mode)
      0: if (elig != 16'h0) begin m_id = lowest(elig); m_mode = 1; end
      1: if (taken) m_mode = 2; else if (!elig[m_id]) m_mode = 0;
      default: if (ret) begin m_clr = 16'h1 << m_id; m_mode = 0; end
    endcase
    m_pend = (m_pend & ~m_clr) | rise;
    samp.push_front(src);
    void'(samp.pop_back());
    m_req   = (m_mode == 1);
    m_cause = (m_mode == 0) ? 32'h0 : CB + 32'(m_id);
    m_idout = (m_mode == 0) ? 4'h0 : 4'(m_id);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc_n++;
    #1;
    if (model_chk)
      chk($sformatf("model cyc%0d {req,cause,id,clr}", cyc_n),
          {11'h0, irq_req_o, irq_cause_o, irq_id_o, irq_clr_o},
          {11'h0, m_req, m_cause, m_idout, m_clr});
  endtask

  task automatic cyc(input logic [15:0] s, input logic [15:0] e, input logic t, input logic r);
    src = s; en = e; taken = t; ret = r;
    step();
  endtask

  task automatic until_req(input logic [15:0] s, input int max, input string name);
    for (int k = 0; k < max && irq_req_o !== 1'b1; k++) cyc(s, ONES, 1'b0, 1'b0);
    chk({name, ".req_seen"}, irq_req_o, 1'b1);
  endtask

  typedef struct {
    logic [15:0] src;
    logic        taken, ret;
    logic        req;
    logic [31:0] cause;
    logic [3:0]  id;
    logic [15:0] clr;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic [15:0] s, input logic t, input logic r,
                              input logic q, input logic [31:0] c, input logic [3:0] i,
                              input logic [15:0] k);
    vec_t v;
    v.src = s; v.taken = t; v.ret = r; v.req = q; v.cause = c; v.id = i; v.clr = k;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] clr_seen;

    // Edge source 3: request after four edges, then take and return.
    vt.push_back(mk(16'h0008, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 32'h1000_0013, 4'd3, 16'h0));
    vt.push_back(mk(16'h0000, 1'b1, 1'b0, 1'b0, 32'h1000_0013, 4'd3, 16'h0));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 32'h1000_0013, 4'd3, 16'h0));
    vt.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 16'h0008));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    // Edge sources 5 and 2 together: 2 first, then 5.
    vt.push_back(mk(16'h0024, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0024, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0024, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));
    vt.push_back(mk(16'h0024, 1'b0, 1'b0, 1'b1, 32'h1000_0012, 4'd2, 16'h0));
    vt.push_back(mk(16'h0024, 1'b1, 1'b0, 1'b0, 32'h1000_0012, 4'd2, 16'h0));
    vt.push_back(mk(16'h0024, 1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 16'h0004));
    vt.push_back(mk(16'h0024, 1'b0, 1'b0, 1'b1, 32'h1000_0015, 4'd5, 16'h0));
    vt.push_back(mk(16'h0024, 1'b1, 1'b0, 1'b0, 32'h1000_0015, 4'd5, 16'h0));
    vt.push_back(mk(16'h0024, 1'b0, 1'b1, 1'b0, 32'h0, 4'd0, 16'h0020));
    vt.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 16'h0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset.req", irq_req_o, 1'b0);
    chk("reset.cause", irq_cause_o, 32'h0);
    chk("reset.id", irq_id_o, 4'h0);
    chk("reset.clr", irq_clr_o, 16'h0);
    model_reset();
    en = ONES;
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].src, ONES, vt[i].taken, vt[i].ret);
      chk($sformatf("vec%0d.req", i), irq_req_o, vt[i].req);
      chk($sformatf("vec%0d.cause", i), irq_cause_o, vt[i].cause);
      chk($sformatf("vec%0d.id", i), irq_id_o, vt[i].id);
      chk($sformatf("vec%0d.clr", i), irq_clr_o, vt[i].clr);
    end
    repeat (3) cyc(16'h0, ONES, 1'b0, 1'b0);
    model_chk = 1'b1;

    // Level source 7 withdraws before being taken.
    cyc(16'h0080, ONES, 1'b0, 1'b0);
    until_req(16'h0080, 6, "t3");
    chk("t3.id", irq_id_o, 4'd7);
    chk("t3.cause", irq_cause_o, 32'h1000_0017);
    clr_seen = 16'h0;
    for (int k = 0; k < 5 && irq_req_o === 1'b1; k++) begin
      cyc(16'h0, ONES, 1'b0, 1'b0);
      clr_seen |= irq_clr_o;
    end
    chk("t3.withdrawn", irq_req_o, 1'b0);
    chk("t3.idle_id", irq_id_o, 4'd0);
    chk("t3.no_clr", clr_seen, 16'h0);

    // Masked edge source 1, then enable; a new edge coincides with return.
    cyc(16'h0002, 16'hFFFD, 1'b0, 1'b0);
    repeat (5) cyc(16'h0, 16'hFFFD, 1'b0, 1'b0);
    chk("t4.masked", irq_req_o, 1'b0);
    cyc(16'h0, ONES, 1'b0, 1'b0);
    chk("t4.unmasked_req", irq_req_o, 1'b1);
    chk("t4.id", irq_id_o, 4'd1);
    cyc(16'h0, ONES, 1'b1, 1'b0);
    cyc(16'h0002, ONES, 1'b0, 1'b0);
    cyc(16'h0, ONES, 1'b0, 1'b0);
    cyc(16'h0, ONES, 1'b0, 1'b1);
    chk("t4.clr", irq_clr_o, 16'h0002);
    until_req(16'h0, 3, "t4.rereq");
    chk("t4.rereq_id", irq_id_o, 4'd1);
    cyc(16'h0, ONES, 1'b1, 1'b0);
    cyc(16'h0, ONES, 1'b0, 1'b1);
    repeat (2) cyc(16'h0, ONES, 1'b0, 1'b0);

    // No preemption in REQ; return outside service ignored.
    cyc(16'h0010, ONES, 1'b0, 1'b0);
    until_req(16'h0, 6, "t6");
    chk("t6.id", irq_id_o, 4'd4);
    cyc(16'h0001, ONES, 1'b0, 1'b1);
    repeat (4) cyc(16'h0, ONES, 1'b0, 1'b1);
    chk("t6.no_preempt_id", irq_id_o, 4'd4);
    chk("t6.still_req", irq_req_o, 1'b1);
    cyc(16'h0, ONES, 1'b1, 1'b0);
    cyc(16'h0, ONES, 1'b0, 1'b1);
    chk("t6.clr", irq_clr_o, 16'h0010);
    until_req(16'h0, 3, "t6.next");
    chk("t6.next_id", irq_id_o, 4'd0);
    cyc(16'h0, ONES, 1'b1, 1'b0);
    cyc(16'h0, ONES, 1'b0, 1'b1);
    repeat (2) cyc(16'h0, ONES, 1'b0, 1'b0);

    // Asynchronous reset during service drops everything, including other pending edges.
    cyc(16'h0408, ONES, 1'b0, 1'b0);
    until_req(16'h0, 6, "t5");
    chk("t5.id", irq_id_o, 4'd3);
    cyc(16'h0, ONES, 1'b1, 1'b0);
    chk("t5.svc_req", irq_req_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.rst.req", irq_req_o, 1'b0);
    chk("t5.rst.cause", irq_cause_o, 32'h0);
    chk("t5.rst.id", irq_id_o, 4'h0);
    chk("t5.rst.clr", irq_clr_o, 16'h0);
    model_reset();
    #3 rst_n = 1'b1;
    repeat (8) cyc(16'h0, ONES, 1'b0, 1'b0);
    chk("t5.no_req_after", irq_req_o, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] s, e;
      s = src;
      if ($urandom_range(3, 0) == 0) s = s ^ (16'h1 << $urandom_range(15, 0));
      e = ($urandom_range(7, 0) == 0) ? 16'($urandom) : ONES;
      cyc(s, e, ($urandom_range(2, 0) == 0), ($urandom_range(3, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
